hr_alarm_monitor: RTL and testbench
===================================

# hr_alarm_monitor

Rhythm-alarm stage directly downstream of the heart-rate estimator. Consumes the estimator's `peak_detected` strobe and `bpm` word. Classifies each beat as normal, bradycardic or tachycardic, and raises debounced alarms after a run of consecutive abnormal beats. Also runs an asystole watchdog that fires when no peak arrives within a programmable window.

## Interface
- `CLK_FREQ`, 200: clock frequency in Hz; must match the estimator.
- `BRADY_BPM`, 50: beats with `bpm` strictly below this value are brady.
- `TACHY_BPM`, 120: beats with `bpm` strictly above this value are tachy. Must be ≥ `BRADY_BPM`.
- `CONFIRM_BEATS`, 3: length of the consecutive same-class beat run needed to change alarm state (≥1).
- `WARMUP_BEATS`, 5: number of peaks ignored after reset or asystole while the RR averager refills (≥1).
- `ASYSTOLE_SEC`, 3: no-peak window in seconds. `ASYS_CYCLES = ASYSTOLE_SEC*CLK_FREQ`.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset (asserted at 0).
- `peak_detected`, input, 1: one-cycle beat strobe from the peak detector.
- `bpm`, input, 32: current heart rate from the BPM calculator. It is sampled only in cycles where `peak_detected`=1.
- `alarm_brady`, output, 1: high while the state is BRADY.
- `alarm_tachy`, output, 1: high while the state is TACHY.
- `alarm_asystole`, output, 1: high while the state is ASYSTOLE.
- `hr_valid`, output, 1: high in NORMAL, BRADY and TACHY.
- `alarm_irq`, output, 1: one-cycle pulse on entry into BRADY, TACHY or ASYSTOLE from any other state.
- `last_bpm`, output, 32: `bpm` value of the most recent classified beat.

## Operation
- States: WARMUP, NORMAL, BRADY, TACHY, ASYSTOLE.
- Reset state:
  - State = WARMUP; warm_cnt, streak_cnt, idle_cnt and `last_bpm` are 0.
  - streak_cls = NORMAL.
  - All outputs are 0.
- Idle counter:
  - A cycle with `peak_detected`=1 clears idle_cnt to 0.
  - Otherwise idle_cnt increments, saturating at `ASYS_CYCLES`.
  - The increment that reaches `ASYS_CYCLES` forces the state to ASYSTOLE from any state, including WARMUP.
- WARMUP: each peak increments warm_cnt. On the peak that makes warm_cnt = `WARMUP_BEATS`, go to NORMAL and clear the streak. No classification happens in WARMUP.
- NORMAL, BRADY and TACHY each handle a peak in three steps:
  - Skip check: if `bpm`=0 (estimator not primed), ignore the beat entirely. The streak, `last_bpm` and the state do not change.
  - Classify: cls = BRADY if `bpm` < `BRADY_BPM`; TACHY if `bpm` > `TACHY_BPM`; else NORMAL. Threshold-equal values are NORMAL. Then `last_bpm` ← `bpm`.
  - Streak update: if cls = streak_cls, streak_cnt increments, saturating at `CONFIRM_BEATS`; otherwise streak_cls ← cls and streak_cnt ← 1.
- State change: if the updated streak_cnt = `CONFIRM_BEATS` and cls ≠ the current state, the state becomes cls.
  - BRADY→TACHY and TACHY→BRADY are allowed directly.
  - Return to NORMAL requires `CONFIRM_BEATS` consecutive normal beats.
- ASYSTOLE:
  - idle_cnt holds at saturation.
  - The first peak moves the state to WARMUP with warm_cnt = 1 and clears the streak.
  - `last_bpm` is held.
- Comparisons are unsigned 32-bit. `ASYS_CYCLES` is computed at elaboration; idle_cnt is 32 bits wide.

## Timing
- All outputs are registered.
- A peak sampled at edge N produces its state change, `last_bpm` update and `alarm_irq` pulse visible after edge N (1-cycle latency).
- `alarm_irq` is high for exactly one cycle per alarm entry.
- No pulse is generated for entry into NORMAL, WARMUP or exit from any alarm.
- A BRADY→TACHY change pulses `alarm_irq` once.
- Peak in the same cycle idle_cnt would reach `ASYS_CYCLES`: the peak wins. No asystole occurs, and idle_cnt → 0.
- Asystole entry: the `ASYS_CYCLES`-th consecutive edge without a peak after the last peak, or after reset release.
- Back-to-back peaks in consecutive cycles are each processed.
- Asserting `rst` mid-operation clears everything immediately (asynchronously), including a pending `alarm_irq`.

## Test plan
- Warmup: five peaks at `bpm`=72 spaced 160 cycles apart → `hr_valid` rises after the 5th peak's edge; all alarms stay 0, `alarm_irq` never pulses.
- Brady debounce: after warmup, send peaks at bpm 45, 45, 72, 45, 45, 45 → `alarm_brady` rises and `alarm_irq` pulses once, both after the 6th peak only. `last_bpm`=45.
- Threshold edges: beats at `bpm`=50 and `bpm`=120 stay NORMAL. Three beats at 121 → TACHY. Three beats at 49 → BRADY with a single `alarm_irq` pulse; `alarm_tachy` falls in the same cycle.
- Asystole: in NORMAL, no peak for 600 cycles → `alarm_asystole`=1 and `alarm_irq` pulses exactly at edge 600. A peak with no gap after 599 silent cycles does not trigger asystole. After asystole, one peak → WARMUP, and `hr_valid` returns only after 4 further peaks.
- Zero bpm: during a tachy streak of 2, a peak with `bpm`=0 → streak unchanged and `last_bpm` unchanged; the next beat at 130 completes TACHY.
- Reset mid-alarm: drive `rst`=0 asynchronously while in BRADY → all outputs 0 immediately; after release, the state is WARMUP.

Source files
------------

// File: rtl/hr_alarm_monitor.sv
// Rhythm-alarm stage: classifies beats from the heart-rate estimator, debounces
// brady/tachy alarms over a run of beats, and watches for asystole (no peaks).
module hr_alarm_monitor #(
  parameter int unsigned CLK_FREQ      = 200,
  parameter int unsigned BRADY_BPM     = 50,
  parameter int unsigned TACHY_BPM     = 120,
  parameter int unsigned CONFIRM_BEATS = 3,
  parameter int unsigned WARMUP_BEATS  = 5,
  parameter int unsigned ASYSTOLE_SEC  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        peak_detected,
  input  logic [31:0] bpm,
  output logic        alarm_brady,
  output logic        alarm_tachy,
  output logic        alarm_asystole,
  output logic        hr_valid,
  output logic        alarm_irq,
  output logic [31:0] last_bpm,
  output logic [2:0]  dbg_state
);

  localparam logic [31:0] ASYS_CYCLES = ASYSTOLE_SEC * CLK_FREQ;

  typedef enum logic [2:0] {
    ST_WARMUP   = 3'd0,
    ST_NORMAL   = 3'd1,
    ST_BRADY    = 3'd2,
    ST_TACHY    = 3'd3,
    ST_ASYSTOLE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  state_e      streak_cls_q, streak_cls_d;
  state_e      cls;
  logic [31:0] warm_q, warm_d;
  logic [31:0] streak_cnt_q, streak_cnt_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] last_bpm_q, last_bpm_d;
  logic        irq_q, irq_d;
  logic        brady_q, tachy_q, asys_q, valid_q;
  logic        idle_expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_WARMUP;
      streak_cls_q <= ST_NORMAL;
      warm_q       <= '0;
      streak_cnt_q <= '0;
      idle_q       <= '0;
      last_bpm_q   <= '0;
      irq_q        <= 1'b0;
      brady_q      <= 1'b0;
      tachy_q      <= 1'b0;
      asys_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_cls_q <= streak_cls_d;
      warm_q       <= warm_d;
      streak_cnt_q <= streak_cnt_d;
      idle_q       <= idle_d;
      last_bpm_q   <= last_bpm_d;
      irq_q        <= irq_d;
      brady_q      <= (state_d == ST_BRADY);
      tachy_q      <= (state_d == ST_TACHY);
      asys_q       <= (state_d == ST_ASYSTOLE);
      valid_q      <= (state_d == ST_NORMAL) || (state_d == ST_BRADY) ||
                      (state_d == ST_TACHY);
    end
  end

  always_comb begin
    state_d      = state_q;
    streak_cls_d = streak_cls_q;
    warm_d       = warm_q;
    streak_cnt_d = streak_cnt_q;
    idle_d       = idle_q;
    last_bpm_d   = last_bpm_q;
    cls          = ST_NORMAL;
    idle_expire  = 1'b0;

    // A peak always wins over the watchdog reaching its limit in the same cycle.
    if (peak_detected) begin
      idle_d = '0;
    end else if (idle_q < ASYS_CYCLES) begin
      idle_d      = idle_q + 32'd1;
      idle_expire = (idle_d == ASYS_CYCLES);
    end

    case (state_q)
      ST_WARMUP: begin
        if (peak_detected) begin
          warm_d = warm_q + 32'd1;
          if (warm_d >= WARMUP_BEATS) begin
            state_d      = ST_NORMAL;
            streak_cls_d = ST_NORMAL;
            streak_cnt_d = '0;
          end
        end
      end
      ST_NORMAL, ST_BRADY, ST_TACHY: begin
        // bpm of 0 means the estimator has not primed yet; the beat is dropped.
        if (peak_detected && (bpm != 32'd0)) begin
          if (bpm < BRADY_BPM)      cls = ST_BRADY;
          else if (bpm > TACHY_BPM) cls = ST_TACHY;
          else                      cls = ST_NORMAL;
          last_bpm_d = bpm;
          if (cls == streak_cls_q) begin
            if (streak_cnt_q < CONFIRM_BEATS) streak_cnt_d = streak_cnt_q + 32'd1;
          end else begin
            streak_cls_d = cls;
            streak_cnt_d = 32'd1;
          end
          if ((streak_cnt_d == CONFIRM_BEATS) && (cls != state_q)) state_d = cls;
        end
      end
      ST_ASYSTOLE: begin
        if (peak_detected) begin
          state_d      = ST_WARMUP;
          warm_d       = 32'd1;
          streak_cls_d = ST_NORMAL;
          streak_cnt_d = '0;
        end
      end
      default: state_d = ST_WARMUP;
    endcase

    if (idle_expire) state_d = ST_ASYSTOLE;

    irq_d = (state_d != state_q) &&
            ((state_d == ST_BRADY) || (state_d == ST_TACHY) || (state_d == ST_ASYSTOLE));
  end

  assign alarm_brady    = brady_q;
  assign alarm_tachy    = tachy_q;
  assign alarm_asystole = asys_q;
  assign hr_valid       = valid_q;
  assign alarm_irq      = irq_q;
  assign last_bpm       = last_bpm_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_hr_alarm_monitor.sv
// Directed bench for hr_alarm_monitor: expected output vectors are queued as
// each step is driven and compared one cycle later against the registered outputs.
module tb_hr_alarm_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        peak_detected;
  logic [31:0] bpm;
  logic        alarm_brady, alarm_tachy, alarm_asystole, hr_valid, alarm_irq;
  logic [31:0] last_bpm;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  // {brady, tachy, asystole, hr_valid, irq, last_bpm}
  logic [36:0] exp_q[$];

  hr_alarm_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .peak_detected  (peak_detected),
    .bpm            (bpm),
    .alarm_brady    (alarm_brady),
    .alarm_tachy    (alarm_tachy),
    .alarm_asystole (alarm_asystole),
    .hr_valid       (hr_valid),
    .alarm_irq      (alarm_irq),
    .last_bpm       (last_bpm),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input logic b, input logic t, input logic a,
                            input logic v, input logic i, input logic [31:0] lb);
    exp_q.push_back({b, t, a, v, i, lb});
  endtask

  task automatic check(input string tag);
    logic [36:0] obs;
    logic [36:0] exp;
    obs = {alarm_brady, alarm_tachy, alarm_asystole, hr_valid, alarm_irq, last_bpm};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %h but no expected value queued", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic beat(input logic [31:0] v, input logic b, input logic t, input logic a,
                      input logic vl, input logic i, input logic [31:0] lb, input string tag);
    expect_out(b, t, a, vl, i, lb);
    peak_detected = 1'b1;
    bpm           = v;
    @(posedge clk);
    #1;
    peak_detected = 1'b0;
    bpm           = $urandom;
    check(tag);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst           = 1'b0;
    peak_detected = 1'b0;
    bpm           = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out(0, 0, 0, 0, 0, 32'd0);
    check("reset_outputs");
    tests++;
    assert (dbg_state === 3'd0) else begin
      fails++;
      $error("FAIL reset_state: observed %0d expected 0", dbg_state);
    end
    rst = 1'b1;

    // Warmup: peaks are counted but not classified
    for (int k = 1; k <= 4; k++) begin
      gap(159);
      beat(32'd72, 0, 0, 0, 0, 0, 32'd0, "warmup_peak");
    end
    gap(159);
    beat(32'd72, 0, 0, 0, 1, 0, 32'd0, "warmup_done");

    // Brady debounce interrupted by a normal beat
    gap($urandom_range(300, 50)); beat(32'd45, 0, 0, 0, 1, 0, 32'd45, "brady_1");
    gap($urandom_range(300, 50)); beat(32'd45, 0, 0, 0, 1, 0, 32'd45, "brady_2");
    gap($urandom_range(300, 50)); beat(32'd72, 0, 0, 0, 1, 0, 32'd72, "brady_break");
    gap($urandom_range(300, 50)); beat(32'd45, 0, 0, 0, 1, 0, 32'd45, "brady_r1");
    gap($urandom_range(300, 50)); beat(32'd45, 0, 0, 0, 1, 0, 32'd45, "brady_r2");
    gap($urandom_range(300, 50)); beat(32'd45, 1, 0, 0, 1, 1, 32'd45, "brady_enter");
    expect_out(1, 0, 0, 1, 0, 32'd45); gap(1); check("brady_irq_drop");

    // Thresholds: equal values are normal; back-to-back beats
    beat(32'd50,  1, 0, 0, 1, 0, 32'd50,  "thr_50");
    beat(32'd120, 1, 0, 0, 1, 0, 32'd120, "thr_120");
    beat(32'd50,  0, 0, 0, 1, 0, 32'd50,  "back_to_normal");
    gap(20);
    beat(32'd120, 0, 0, 0, 1, 0, 32'd120, "normal_sat");
    beat(32'd121, 0, 0, 0, 1, 0, 32'd121, "tachy_1");
    beat(32'd121, 0, 0, 0, 1, 0, 32'd121, "tachy_2");
    beat(32'd121, 0, 1, 0, 1, 1, 32'd121, "tachy_enter");
    expect_out(0, 1, 0, 1, 0, 32'd121); gap(1); check("tachy_irq_drop");
    gap(30);
    beat(32'd49, 0, 1, 0, 1, 0, 32'd49, "t2b_1");
    beat(32'd49, 0, 1, 0, 1, 0, 32'd49, "t2b_2");
    beat(32'd49, 1, 0, 0, 1, 1, 32'd49, "tachy_to_brady");
    expect_out(1, 0, 0, 1, 0, 32'd49); gap(1); check("t2b_irq_drop");

    // Zero bpm is skipped mid-streak
    gap(40);
    beat(32'd130, 1, 0, 0, 1, 0, 32'd130, "zero_pre1");
    beat(32'd130, 1, 0, 0, 1, 0, 32'd130, "zero_pre2");
    gap(10);
    beat(32'd0,   1, 0, 0, 1, 0, 32'd130, "zero_skip");
    gap(10);
    beat(32'd130, 0, 1, 0, 1, 1, 32'd130, "zero_then_tachy");

    // Back to normal, then asystole watchdog
    gap(25);
    beat(32'd72, 0, 1, 0, 1, 0, 32'd72, "n_1");
    beat(32'd72, 0, 1, 0, 1, 0, 32'd72, "n_2");
    beat(32'd72, 0, 0, 0, 1, 0, 32'd72, "n_3_no_irq");
    gap(599);
    beat(32'd80, 0, 0, 0, 1, 0, 32'd80, "peak_beats_watchdog");
    expect_out(0, 0, 0, 1, 0, 32'd80); gap(599); check("asys_edge_599");
    expect_out(0, 0, 1, 0, 1, 32'd80); gap(1);   check("asys_edge_600");
    expect_out(0, 0, 1, 0, 0, 32'd80); gap(1);   check("asys_irq_drop");
    gap(50);
    beat(32'd72, 0, 0, 0, 0, 0, 32'd80, "asys_exit_warmup");
    for (int k = 1; k <= 3; k++) begin
      gap(100);
      beat(32'd72, 0, 0, 0, 0, 0, 32'd80, "rewarm");
    end
    gap(100);
    beat(32'd72, 0, 0, 0, 1, 0, 32'd80, "rewarm_done");

    // Asynchronous reset while the brady irq is still high
    beat(32'd40, 0, 0, 0, 1, 0, 32'd40, "pre_rst_1");
    beat(32'd40, 0, 0, 0, 1, 0, 32'd40, "pre_rst_2");
    beat(32'd40, 1, 0, 0, 1, 1, 32'd40, "pre_rst_brady");
    #2;
    rst = 1'b0;
    #1;
    expect_out(0, 0, 0, 0, 0, 32'd0);
    check("async_reset");
    gap(2);
    rst = 1'b1;
    tests++;
    assert (dbg_state === 3'd0) else begin
      fails++;
      $error("FAIL post_reset_state: observed %0d expected 0", dbg_state);
    end
    gap(5);
    beat(32'd72, 0, 0, 0, 0, 0, 32'd0, "post_reset_warmup");

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
